// File: rtl/nios2_qsys_div_cell_if.sv
// Start/done handshake and operand/result bus between the A-stage stall logic
// and the iterative divide cell.
interface nios2_qsys_div_cell_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  A_div_start;
    logic                  A_div_signed;
    logic [DATA_WIDTH-1:0] A_div_src1;
    logic [DATA_WIDTH-1:0] A_div_src2;
    logic                  A_div_busy;
    logic                  A_div_done;
    logic [DATA_WIDTH-1:0] A_div_result;
    logic [DATA_WIDTH-1:0] A_div_remainder;
    logic                  A_div_by_zero;

    modport master (
        output A_div_start, A_div_signed, A_div_src1, A_div_src2,
        input  A_div_busy, A_div_done, A_div_result, A_div_remainder, A_div_by_zero
    );

    modport slave (
        input  A_div_start, A_div_signed, A_div_src1, A_div_src2,
        output A_div_busy, A_div_done, A_div_result, A_div_remainder, A_div_by_zero
    );
endinterface

// File: rtl/nios2_qsys_div_cell.sv
// Radix-2 restoring divider for div/divu: one quotient bit per clock on operand
// magnitudes, with sign fixup and divide-by-zero override in a final FIX cycle.
module nios2_qsys_div_cell #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    nios2_qsys_div_cell_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
    logic [DATA_WIDTH-1:0] src1_raw_q, src1_raw_d;
    logic                  neg_dvd_q, neg_dvd_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  zero_q, zero_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
    logic                  by_zero_q, by_zero_d;
    logic [DATA_WIDTH:0]   shifted_s;
    logic [DATA_WIDTH:0]   trial_s;

    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
        return ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // The most negative value maps to its own bit pattern, read as unsigned.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                       input logic is_signed);
        logic [DATA_WIDTH-1:0] m;
        if (is_signed && v[DATA_WIDTH-1]) begin
            m = negate(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.A_div_start) begin
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        shifted_s   = {rem_q, quo_q[DATA_WIDTH-1]};
        trial_s     = shifted_s - {1'b0, divisor_q};
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        src1_raw_d  = src1_raw_q;
        neg_dvd_d   = neg_dvd_q;
        neg_quo_d   = neg_quo_q;
        zero_d      = zero_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        by_zero_d   = by_zero_q;
        done_d      = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (bus.A_div_start) begin
                    quo_d      = magnitude(bus.A_div_src1, bus.A_div_signed);
                    divisor_d  = magnitude(bus.A_div_src2, bus.A_div_signed);
                    src1_raw_d = bus.A_div_src1;
                    neg_dvd_d  = bus.A_div_signed & bus.A_div_src1[DATA_WIDTH-1];
                    neg_quo_d  = bus.A_div_signed &
                                 (bus.A_div_src1[DATA_WIDTH-1] ^ bus.A_div_src2[DATA_WIDTH-1]);
                    zero_d     = (bus.A_div_src2 == {DATA_WIDTH{1'b0}});
                    rem_d      = {DATA_WIDTH{1'b0}};
                    cnt_d      = CNT_WIDTH'(DATA_WIDTH);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_CALC: begin
                // Negative trial (MSB set) restores the shifted remainder.
                quo_d = {quo_q[DATA_WIDTH-2:0], ~trial_s[DATA_WIDTH]};
                if (trial_s[DATA_WIDTH]) begin
                    rem_d = shifted_s[DATA_WIDTH-1:0];
                end else begin
                    rem_d = trial_s[DATA_WIDTH-1:0];
                end
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
            ST_FIX: begin
                done_d = 1'b1;
                if (zero_q) begin
                    result_d    = {DATA_WIDTH{1'b1}};
                    remainder_d = src1_raw_q;
                    by_zero_d   = 1'b1;
                end else begin
                    result_d    = neg_quo_q ? negate(quo_q) : quo_q;
                    remainder_d = neg_dvd_q ? negate(rem_q) : rem_q;
                    by_zero_d   = 1'b0;
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= {CNT_WIDTH{1'b0}};
            rem_q       <= {DATA_WIDTH{1'b0}};
            quo_q       <= {DATA_WIDTH{1'b0}};
            divisor_q   <= {DATA_WIDTH{1'b0}};
            src1_raw_q  <= {DATA_WIDTH{1'b0}};
            neg_dvd_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= {DATA_WIDTH{1'b0}};
            remainder_q <= {DATA_WIDTH{1'b0}};
            by_zero_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            src1_raw_q  <= src1_raw_d;
            neg_dvd_q   <= neg_dvd_d;
            neg_quo_q   <= neg_quo_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            by_zero_q   <= by_zero_d;
        end
    end

    assign bus.A_div_busy      = busy_q;
    assign bus.A_div_done      = done_q;
    assign bus.A_div_result    = result_q;
    assign bus.A_div_remainder = remainder_q;
    assign bus.A_div_by_zero   = by_zero_q;
endmodule
